// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS trace monitor: record layout, word count and FSM states.
// Build option TRACE_TIMESTAMP_EN adds a 16-bit capture timestamp as a fifth word.
package mips_trace_pkg;
    localparam int WORD_W = 16;

`ifdef TRACE_TIMESTAMP_EN
    localparam int NW = 5;
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] r1;
        logic [WORD_W-1:0] r2;
        logic [WORD_W-1:0] r3;
        logic [WORD_W-1:0] ts;
    } trace_rec_t;
`else
    localparam int NW = 4;
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] r1;
        logic [WORD_W-1:0] r2;
        logic [WORD_W-1:0] r3;
    } trace_rec_t;
`endif

    localparam logic [7:0] DROP_MAX = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsm_state_t;
endpackage

// File: rtl/mips_trace_if.sv
// Outgoing trace word stream. valid/ready: a word transfers on a clock edge where valid & ready;
// once valid is raised, data/last/valid stay unchanged until that transfer happens.
interface mips_trace_if;
    import mips_trace_pkg::*;

    logic [WORD_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/mips_trace_fifo.sv
// Synchronous record FIFO; head is read combinationally so a pop sees the current entry.
module mips_trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   clear_n,
    input  logic                   push,
    input  logic                   pop,
    input  trace_rec_t             wr_data,
    output trace_rec_t             rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    trace_rec_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // When full, a push is only issued alongside a pop; the write lands on the slot being vacated.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
endmodule

// File: rtl/mips_trace_monitor.sv
// Samples pc/r1/r2/r3 into a record FIFO and replays each record as a framed word stream.
// Never back-pressures the core: records that do not fit are dropped and counted. Option: TRACE_TIMESTAMP_EN.
module mips_trace_monitor
    import mips_trace_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter bit CHANGE_ONLY = 1'b1
) (
    input  logic                   clk,
    input  logic                   clear_n,
    input  logic                   trace_en,
    input  logic [WORD_W-1:0]      pc,
    input  logic [WORD_W-1:0]      r1,
    input  logic [WORD_W-1:0]      r2,
    input  logic [WORD_W-1:0]      r3,
    mips_trace_if.master           stream,
    output logic                   overflow,
    output logic [7:0]             drop_count,
    input  logic                   clr_ovf,
    output fsm_state_t             state,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int REC_W = $bits(trace_rec_t);
    localparam int IW    = $clog2(NW);
    localparam logic [IW-1:0] LAST_IDX = IW'(NW-1);

    trace_rec_t            cur_rec;
    trace_rec_t            head_rec;
    logic [4*WORD_W-1:0]   last_cap_q;
    logic                  first_q;
    logic                  capture;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  full;
    logic                  empty;
    fsm_state_t            state_q;
    fsm_state_t            state_d;
    logic [IW-1:0]         idx_q;
    logic [IW-1:0]         idx_d;
    logic [REC_W-1:0]      shift_q;
    logic [REC_W-1:0]      shift_d;

`ifdef TRACE_TIMESTAMP_EN
    logic [WORD_W-1:0] ts_q;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + WORD_W'(1);
        end
    end
`endif

    always_comb begin
        cur_rec    = '0;
        cur_rec.pc = pc;
        cur_rec.r1 = r1;
        cur_rec.r2 = r2;
        cur_rec.r3 = r3;
`ifdef TRACE_TIMESTAMP_EN
        cur_rec.ts = ts_q;
`endif
    end

    // The change filter compares register values only; the timestamp always differs.
    assign capture = trace_en && (!CHANGE_ONLY || first_q || ({pc, r1, r2, r3} != last_cap_q));
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            last_cap_q <= '0;
            first_q    <= 1'b1;
        end else if (capture) begin
            last_cap_q <= {pc, r1, r2, r3};
            first_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clr_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != DROP_MAX) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    mips_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .clear_n (clear_n),
        .push    (push),
        .pop     (pop),
        .wr_data (cur_rec),
        .rd_data (head_rec),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // The current word always sits in the top slot of the shift register; PC is the MSB field.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head_rec;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (stream.ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = head_rec;
                        end else begin
                            shift_d = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shift_d = shift_q << WORD_W;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stream.valid = (state_q == SEND);
    assign stream.data  = shift_q[REC_W-1 -: WORD_W];
    assign stream.last  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign state        = state_q;
endmodule
